pad_in_conditioner: RTL
=======================

# pad_in_conditioner

Input-conditioning stage between the input pad ring and `pulpino_top`. It synchronises the raw pad reset and slow control/status inputs into the core clock domain. It debounces the control/status inputs and sequences a clean core reset. `pulpino_top` consumes `core_rst_n_o` (its `rst_n`) and `dout_o` (fetch enable, UART CTS/DSR, spare) instead of the raw pad signals.

## Interface
Parameters:
- `NCH`, 4: number of debounced channels. Bit 0 is fetch_enable, 1 is uart_cts, 2 is uart_dsr, 3 is spare.
- `SYNC_STAGES`, 2: flip-flop depth of every synchroniser; legal values ≥ 2.
- `DEBOUNCE_CYCLES`, 16: consecutive cycles of a changed level before `dout_o` follows; legal values ≥ 1.
- `RST_HOLD_CYCLES`, 64: cycles the synchronised pad reset must stay released before the core leaves reset; legal values ≥ 1.

Ports:
- `clk`  in  1: core clock; the single clock of the block.
- `rst`  in  1: synchronous, active-high block reset (global power-on reset).
- `rst_pad_n_i`  in  1: raw, asynchronous pad reset; active low.
- `din_i`  in  NCH: raw, asynchronous pad inputs.
- `dout_o`  out  NCH: synchronised, debounced levels.
- `rise_o`  out  NCH: one-cycle pulse on a 0→1 change of `dout_o[i]`.
- `fall_o`  out  NCH: one-cycle pulse on a 1→0 change of `dout_o[i]`.
- `core_rst_n_o`  out  1: active-low reset to `pulpino_top`.

## Operation
Synchronisers:
- Each `din_i[i]` and `rst_pad_n_i` passes through its own `SYNC_STAGES`-deep flip-flop chain. The last-stage value is called `s_i` / `s_rst`.
- All chain flops reset to 0, so `s_rst` = 0 and the core is held in reset.

Debounce, per channel:
- Counter `cnt_i` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and saturation-free.
- If `s_i == dout_o[i]`, `cnt_i` <= 0.
- Else if `cnt_i == DEBOUNCE_CYCLES-1`: `dout_o[i]` <= `s_i`, `cnt_i` <= 0, and the matching `rise_o[i]`/`fall_o[i]` <= 1.
- Else `cnt_i` <= `cnt_i+1`.
- `rise_o`/`fall_o` are otherwise 0. They are high for exactly the one cycle in which `dout_o` first shows its new value.
- Any glitch on `s_i` shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never reaches `dout_o`.
- Channels are fully independent. Simultaneous changes on several channels each produce their own pulses in the same cycle.

Reset sequencer (FSM), counter `rcnt` is `$clog2(RST_HOLD_CYCLES+1)` bits:
- HOLD: `core_rst_n_o`=0, `rcnt`=0. If `s_rst`=1, go to COUNT with `rcnt` <= 1.
- COUNT: `core_rst_n_o`=0.
  - If `s_rst`=0, go to HOLD and clear `rcnt`.
  - Else if `rcnt == RST_HOLD_CYCLES`, go to RUN.
  - Else `rcnt` <= `rcnt+1`.
- RUN: `core_rst_n_o`=1. If `s_rst`=0, go to HOLD; `core_rst_n_o` is 0 from that edge.
- `core_rst_n_o` is a registered output decoded as state==RUN. It is never combinational from a pad.
- `dout_o` debouncing runs regardless of FSM state. Gating of fetch enable by reset is the core's job.

Block reset:
- `rst`=1 at an edge sets these values, overriding everything: all sync flops 0, `dout_o`=0, `rise_o`=0, `fall_o`=0, all counters 0, state HOLD, `core_rst_n_o`=0.
- This holds whether `rst` asserts at power-up or mid-operation, including mid-count.
- After `rst` deasserts, operation restarts from HOLD.

## Timing
Numbering: edge 1 is the first edge that samples a pad change.
- Debounced path: `s_i` changes after edge `SYNC_STAGES`. `dout_o` and its pulse update at edge `SYNC_STAGES+DEBOUNCE_CYCLES` (default 18), provided the pad stays stable throughout.
- Reset release: `s_rst` rises after edge `SYNC_STAGES`. `core_rst_n_o` rises at edge `SYNC_STAGES+RST_HOLD_CYCLES+1` (default 67).
- Reset assertion from RUN: `core_rst_n_o` falls at edge `SYNC_STAGES+1` (default 3). There is no debounce on reset assertion.
- No combinational paths from inputs to outputs.

## Test plan
- Power-up: hold `rst`=1 for 3 cycles, then drive `rst_pad_n_i`=1 and `din_i`=4'b0000. Required: all outputs 0 during reset; `core_rst_n_o`=1 exactly 67 edges after the first sample of `rst_pad_n_i`=1.
- Clean edge: `din_i[0]` 0→1 held. Required: `dout_o[0]`=1 and `rise_o[0]` pulse, both at edge 18; pulse lasts 1 cycle; other channels are unchanged.
- Glitch rejection: `din_i[1]` high for 15 cycles, then low. Required: `dout_o[1]` stays 0 and no pulses. A 16-cycle-or-longer high produces `rise_o[1]`, and a later stable low produces `fall_o[1]`.
- Reset bounce: `rst_pad_n_i` released, then pulled low for 1 cycle at count 40. Required: FSM returns to HOLD, and `core_rst_n_o` rises only 64+1 cycles after `s_rst` is high again.
- Run-time reset: in RUN, `rst_pad_n_i`=0. Required: `core_rst_n_o`=0 at edge 3. Re-release re-runs the full 64-cycle hold.
- Mid-operation `rst`: assert `rst` while a channel is at `cnt`=10 and the FSM is in COUNT. Required: the next edge gives all outputs 0 and state HOLD, and no pulses appear after `rst` deasserts unless the pads change.

Source files
------------

// File: rtl/pad_in_conditioner_if.sv
// Pad-side signal bundle of the input conditioner: raw pad inputs in,
// synchronised/debounced levels, edge pulses and the sequenced core reset out.
interface pad_in_conditioner_if #(
    parameter int NCH = 4
);
    logic           rst_pad_n_i;
    logic [NCH-1:0] din_i;
    logic [NCH-1:0] dout_o;
    logic [NCH-1:0] rise_o;
    logic [NCH-1:0] fall_o;
    logic           core_rst_n_o;

    modport master (
        output rst_pad_n_i, din_i,
        input  dout_o, rise_o, fall_o, core_rst_n_o
    );

    modport slave (
        input  rst_pad_n_i, din_i,
        output dout_o, rise_o, fall_o, core_rst_n_o
    );
endinterface

// File: rtl/pad_in_conditioner.sv
// Synchronises raw pad reset and control inputs into the core clock domain,
// debounces each control channel and sequences a clean core reset.
module pad_in_conditioner #(
    parameter int NCH             = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RST_HOLD_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    pad_in_conditioner_if.slave  pads
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(RST_HOLD_CYCLES);

    typedef enum logic [1:0] {HOLD, COUNT, RUN} state_t;

    logic [SYNC_STAGES-1:0][NCH-1:0] din_sync;
    logic [SYNC_STAGES-1:0]          rst_sync;
    logic [NCH-1:0]                  s_din;
    logic                            s_rst;

    logic [NCH-1:0] dout_q, rise_q, fall_q;
    logic [CW-1:0]  cnt [NCH];

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          core_rst_n_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_sync <= '0;
            rst_sync <= '0;
        end else begin
            din_sync <= {din_sync[SYNC_STAGES-2:0], pads.din_i};
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], pads.rst_pad_n_i};
        end
    end

    assign s_din = din_sync[SYNC_STAGES-1];
    assign s_rst = rst_sync[SYNC_STAGES-1];

    // NOTE: the per-channel counter array is reset explicitly; it is a handful
    // of flops, not a RAM, and a stale count would leak a pulse after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (s_din[i] == dout_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    dout_q[i] <= s_din[i];
                    rise_q[i] <= s_din[i];
                    fall_q[i] <= ~s_din[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            HOLD: begin
                rcnt_d = '0;
                if (s_rst) begin
                    state_d = COUNT;
                    rcnt_d  = RW'(1);
                end
            end
            COUNT: begin
                if (!s_rst) begin
                    state_d = HOLD;
                    rcnt_d  = '0;
                end else if (rcnt_q == RCNT_LAST) begin
                    state_d = RUN;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            RUN: begin
                if (!s_rst) begin
                    state_d = HOLD;
                    rcnt_d  = '0;
                end
            end
            default: begin
                state_d = HOLD;
                rcnt_d  = '0;
            end
        endcase
    end

    // Core reset is a flop decoded from the next state, so it changes on the
    // same edge as the state and never sees a pad combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HOLD;
            rcnt_q       <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            core_rst_n_q <= (state_d == RUN);
        end
    end

    assign pads.dout_o       = dout_q;
    assign pads.rise_o       = rise_q;
    assign pads.fall_o       = fall_q;
    assign pads.core_rst_n_o = core_rst_n_q;

endmodule
